// File: rtl/uart_tx_arbiter_if.sv
// Bundles the source-side byte streams and the UART TX byte handshake
// that the arbiter sits between.
//   i_req/i_data/i_last : per-source byte valid, byte, end-of-message flag
//   i_cts/i_idle        : TX accepts the presented byte / TX line idle
//   o_data/o_req        : byte and byte-valid presented to TX
//   o_ack               : one-hot, granted source's byte consumed this cycle
//   o_grant             : one-hot current owner (zero when none)
//   o_busy/o_timeout    : SEND or GAP in progress / watchdog release pulse
// master: the environment (sources + TX); slave: the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   i_req;
  logic [8*N_REQ-1:0] i_data;
  logic [N_REQ-1:0]   i_last;
  logic               i_cts;
  logic               i_idle;
  logic [7:0]         o_data;
  logic               o_req;
  logic [N_REQ-1:0]   o_ack;
  logic [N_REQ-1:0]   o_grant;
  logic               o_busy;
  logic               o_timeout;

  modport master (
    output i_req, i_data, i_last, i_cts, i_idle,
    input  o_data, o_req, o_ack, o_grant, o_busy, o_timeout
  );

  modport slave (
    input  i_req, i_data, i_last, i_cts, i_idle,
    output o_data, o_req, o_ack, o_grant, o_busy, o_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX byte channel
// between N_REQ message sources, with a programmable idle gap after each
// message and a byte-count watchdog.
//   clk : clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : uart_tx_arbiter_if slave modport (sources in, TX handshake out)
module uart_tx_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned MAX_BYTES  = 512
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(MAX_BYTES + 1);
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  logic [N_REQ-1:0] grant;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    rr_ptr;
  logic [CW-1:0]    byte_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             timeout;

  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic [PW-1:0]    rr_next_c;
  int unsigned      cand;
  logic             req_c;
  logic             xfer_c;
  logic             last_c;
  logic             cnt_max_c;
  logic [7:0]       data_sel_c;

  // First requester at or after rr_ptr, searching cyclically; the wrap is
  // an explicit subtract so non-power-of-two N_REQ works.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!pick_valid && bus.i_req[PW'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(cand);
      end
    end
  end

  assign rr_next_c  = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);

  // Granted source's stream is passed straight through while sending.
  assign req_c      = (state == SEND) && bus.i_req[grant_idx];
  assign data_sel_c = bus.i_data[8*grant_idx +: 8];
  assign xfer_c     = req_c && bus.i_cts;
  assign last_c     = bus.i_last[grant_idx];
  assign cnt_max_c  = (byte_cnt == CW'(MAX_BYTES - 1));

  assign bus.o_req     = req_c;
  assign bus.o_data    = req_c ? data_sel_c : 8'h00;
  assign bus.o_ack     = xfer_c ? grant : '0;
  assign bus.o_grant   = grant;
  assign bus.o_busy    = (state != IDLE);
  assign bus.o_timeout = timeout;

  // Arbitration FSM: grant in IDLE, hold for the whole message, then gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_idle && pick_valid) begin
            grant     <= N_REQ'(1) << pick_idx;
            grant_idx <= pick_idx;
            rr_ptr    <= rr_next_c;
            byte_cnt  <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          // Without a transfer nothing moves: the grant is locked.
          if (xfer_c) begin
            byte_cnt <= byte_cnt + CW'(1);
            if (last_c || cnt_max_c) begin
              grant   <= '0;
              timeout <= cnt_max_c && !last_c;
              if (GAP_CYCLES == 0) begin
                state <= IDLE;
              end else begin
                state   <= GAP;
                gap_cnt <= GW'(GAP_CYCLES);
              end
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt == GW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
